countdown_round_ctrl: RTL and testbench
=======================================

// Module: countdown_round_ctrl
// PURPOSE
//   Round sequencer for the Countdown timer datapath (clk/reset/stop/from -> current/win/lose).
//   Runs a multi-round game: computes each round's start value from the level, arms and stops the
//   timer, and collects win/lose. Tracks level, score and lives, and ends the game at zero lives.
//   Sits between the debounced, synchronised buttons and the Countdown instance.
// PARAMETERS
//   START_FROM   20  cd_from for level 0 (7-bit)
//   STEP          2  cd_from decrement per level
//   MIN_FROM      5  floor for cd_from
//   NUM_LEVELS    8  level saturates at NUM_LEVELS-1
//   LIVES         3  lives at game start (1..3)
//   HOLD_CYCLES  50000000  cycles RESULT is held before the next round
// PORTS
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high
//   start_btn   in   1  start/restart button (level, synchronous, debounced)
//   stop_btn    in   1  player stop button (level, synchronous, debounced)
//   cd_win      in   1  Countdown win flag
//   cd_lose     in   1  Countdown lose flag
//   cd_reset    out  1  one-cycle arm pulse to Countdown reset
//   cd_stop     out  1  one-cycle stop pulse to Countdown stop
//   cd_from     out  7  round start value to Countdown from
//   level       out  3  current level
//   score       out  8  score, saturating at 255
//   lives       out  2  remaining lives
//   round_active out 1  high in RUN
//   last_win    out  1  result of the most recent round
//   game_over   out  1  high in OVER
// BEHAVIOUR
//   One clock (clk); reset is synchronous and active-high.
//   Reset values: cd_reset=0, cd_stop=0, cd_from=START_FROM, level=0, score=0, lives=LIVES,
//     round_active=0, last_win=0, game_over=0. The state is FLUSH.
//   Buttons: rising-edge detected. One pulse per press; holding a button has no further effect.
//   FLUSH (1 cycle): cd_stop=1 to freeze a Countdown left running by a mid-game reset -> IDLE.
//   IDLE: cd_win and cd_lose are ignored. A start edge clears score, level and lives, sets
//     cd_from=START_FROM, and goes to ARM.
//   ARM (1 cycle): cd_reset=1 -> RUN. Countdown clears win/lose on the same edge.
//   RUN: on a stop edge, drive cd_stop=1 for 1 cycle (at most once per round).
//     If cd_win|cd_lose, go to RESULT. When both are set, the round is a lose.
//     If the stop edge and cd_lose/cd_win occur in the same cycle, the result wins and cd_stop is suppressed.
//   RESULT entry (single cycle of update):
//     win: last_win=1; score+=1 (saturating); level=min(level+1,NUM_LEVELS-1).
//     lose: last_win=0; lives-=1.
//     cd_from=max(START_FROM-level*STEP, MIN_FROM) using the updated level. Compute with >=10-bit
//     intermediate, so underflow clamps to MIN_FROM and never wraps.
//   RESULT: hold for exactly HOLD_CYCLES cycles (hold counter of $clog2(HOLD_CYCLES+1) bits).
//     Then go to OVER if lives==0, else ARM. Buttons are ignored.
//   OVER: game_over=1. A start edge behaves as it does in IDLE (new game). stop is ignored.
//   Reset mid-operation: all outputs return to reset values and the state goes to FLUSH.
//   All outputs are registered.
// CONFIGURATION
//   STREAK_BONUS_EN defined: a 4-bit win streak (saturating at 15) is kept. A win adds the
//     post-increment streak to score (1,2,3,...), saturating at 255. A lose or new game clears the streak.
//   Not defined: each win adds exactly 1. No streak register.
// STRUCTURE
//   countdown_defs.vh: state encodings (FLUSH/IDLE/ARM/RUN/RESULT/OVER), CD_W=7, SCORE_W=8,
//     LEVEL_W=3, LIVES_W=2. Shared with the Countdown top level.
//   Sub-module btn_edge: registered rising-edge detector, instanced once each for start and stop.
// TESTING  (HOLD_CYCLES=4; Countdown instanced with CLOCK=4)
//   After reset: FLUSH -> cd_stop=1 for 1 cycle -> IDLE, with score=0, lives=3, cd_from=20.
//   start edge -> cd_reset pulse -> RUN. Stop when current==0 -> win, score=1, level=1,
//     cd_from=18, and re-arm after 4 cycles.
//   Three early stops (current!=0) -> lives 3,2,1,0 -> OVER, game_over=1. start -> IDLE-equivalent
//     restart with score=0 and lives=3.
//   Timeout with no stop -> cd_lose -> lives-1, and no cd_stop issued.
//   Drive stop edge and timeout lose in the same cycle -> no cd_stop. Lose counted once.
//   Seven wins -> level saturates at 7, cd_from=max(20-14,5)=6. With START_FROM=10 -> cd_from clamps to 5.
//   Assert reset mid-RUN -> outputs reset, FLUSH stop pulse, stale cd_win ignored in IDLE.
//   With STREAK_BONUS_EN: wins W,W,L,W -> score 1,3,3,4.

Source files
------------

// File: rtl/countdown_round_ctrl_pkg.sv
// Shared types and helpers for the Countdown round sequencer.
// Widths match the Countdown datapath; state encoding is used by the top-level FSM.
package countdown_round_ctrl_pkg;

  localparam int CD_W     = 7;   // Countdown start value width
  localparam int SCORE_W  = 8;   // saturating score width
  localparam int LEVEL_W  = 3;   // level width
  localparam int LIVES_W  = 2;   // lives width
  localparam int STREAK_W = 4;   // win streak / score increment width
  localparam int CALC_W   = 12;  // wide enough that START_FROM - level*STEP cannot wrap

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ARM    = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESULT = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  // Round start value: START_FROM - level*STEP, clamped at MIN_FROM.
  // The subtraction is only taken when it cannot underflow.
  function automatic logic [CD_W-1:0] calc_from(input logic [CALC_W-1:0] start_from,
                                                 input logic [CALC_W-1:0] step,
                                                 input logic [CALC_W-1:0] min_from,
                                                 input logic [LEVEL_W-1:0] lvl);
    logic [CALC_W-1:0] drop;
    logic [CALC_W-1:0] diff;
    drop = CALC_W'(lvl) * step;
    diff = start_from - drop;
    if ((drop + min_from) >= start_from) calc_from = min_from[CD_W-1:0];
    else                                 calc_from = diff[CD_W-1:0];
  endfunction

  // Score addition saturating at the all-ones value.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0]  a,
                                                 input logic [STREAK_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(b);
    if (sum[SCORE_W]) sat_add = '1;
    else              sat_add = sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/countdown_round_ctrl_btn_edge.sv
// Rising-edge detector for an already synchronised, debounced button level.
// The previous level is registered; the pulse is high for the one cycle the button goes 0->1.
module countdown_round_ctrl_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  // Remember the button level from the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/countdown_round_ctrl.sv
// Round sequencer for the Countdown timer: arms/stops the timer, collects win/lose,
// and tracks level, score and lives across a multi-round game.
// Optional feature macro: STREAK_BONUS_EN (win streak adds a growing bonus to score).
module countdown_round_ctrl
  import countdown_round_ctrl_pkg::*;
#(
  parameter int START_FROM  = 20,
  parameter int STEP        = 2,
  parameter int MIN_FROM    = 5,
  parameter int NUM_LEVELS  = 8,
  parameter int LIVES       = 3,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               stop_btn,
  input  logic               cd_win,
  input  logic               cd_lose,
  output logic               cd_reset,
  output logic               cd_stop,
  output logic [CD_W-1:0]    cd_from,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               round_active,
  output logic               last_win,
  output logic               game_over
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic start_edge, stop_edge;

  countdown_round_ctrl_btn_edge u_start_edge (
    .clk(clk), .reset(reset), .btn_i(start_btn), .rise_o(start_edge)
  );
  countdown_round_ctrl_btn_edge u_stop_edge (
    .clk(clk), .reset(reset), .btn_i(stop_btn), .rise_o(stop_edge)
  );

  state_e             state_q, state_d;
  logic [CD_W-1:0]    cd_from_q, cd_from_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               stopped_q, stopped_d;
  logic               cd_reset_q, cd_reset_d;
  logic               cd_stop_q, cd_stop_d;
  logic               last_win_q, last_win_d;
  logic               round_active_q, round_active_d;
  logic               game_over_q, game_over_d;
`ifdef STREAK_BONUS_EN
  logic [STREAK_W-1:0] streak_q, streak_d;
`endif

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_d    = state_q;
    cd_from_d  = cd_from_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    hold_d     = hold_q;
    stopped_d  = stopped_q;
    last_win_d = last_win_q;
    cd_reset_d = 1'b0;
    cd_stop_d  = 1'b0;
`ifdef STREAK_BONUS_EN
    streak_d   = streak_q;
`endif
    case (state_q)
      // Freeze any Countdown left running across a reset.
      ST_FLUSH: begin
        cd_stop_d = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          score_d   = '0;
          level_d   = '0;
          lives_d   = LIVES_W'(LIVES);
          cd_from_d = CD_W'(START_FROM);
          stopped_d = 1'b0;
`ifdef STREAK_BONUS_EN
          streak_d  = '0;
`endif
          // cd_reset is raised while in ARM so Countdown clears before RUN samples flags.
          cd_reset_d = 1'b1;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A result in the same cycle as a stop edge takes priority and swallows the stop.
        if (cd_win || cd_lose) begin
          hold_d  = '0;
          state_d = ST_RESULT;
          if (cd_win && !cd_lose) begin
            last_win_d = 1'b1;
            if (level_q < LEVEL_W'(NUM_LEVELS - 1)) level_d = level_q + 1'b1;
`ifdef STREAK_BONUS_EN
            if (streak_q != '1) streak_d = streak_q + 1'b1;
            score_d = sat_add(score_q, streak_d);
`else
            score_d = sat_add(score_q, STREAK_W'(1));
`endif
          end else begin
            last_win_d = 1'b0;
            if (lives_q != '0) lives_d = lives_q - 1'b1;
`ifdef STREAK_BONUS_EN
            streak_d = '0;
`endif
          end
          cd_from_d = calc_from(CALC_W'(START_FROM), CALC_W'(STEP), CALC_W'(MIN_FROM), level_d);
        end else if (stop_edge && !stopped_q) begin
          cd_stop_d = 1'b1;
          stopped_d = 1'b1;
        end
      end
      ST_RESULT: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          if (lives_q == '0) begin
            state_d = ST_OVER;
          end else begin
            stopped_d  = 1'b0;
            cd_reset_d = 1'b1;
            state_d    = ST_ARM;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
    round_active_d = (state_d == ST_RUN);
    game_over_d    = (state_d == ST_OVER);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_FLUSH;
      cd_from_q      <= CD_W'(START_FROM);
      level_q        <= '0;
      score_q        <= '0;
      lives_q        <= LIVES_W'(LIVES);
      hold_q         <= '0;
      stopped_q      <= 1'b0;
      cd_reset_q     <= 1'b0;
      cd_stop_q      <= 1'b0;
      last_win_q     <= 1'b0;
      round_active_q <= 1'b0;
      game_over_q    <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cd_from_q      <= cd_from_d;
      level_q        <= level_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      hold_q         <= hold_d;
      stopped_q      <= stopped_d;
      cd_reset_q     <= cd_reset_d;
      cd_stop_q      <= cd_stop_d;
      last_win_q     <= last_win_d;
      round_active_q <= round_active_d;
      game_over_q    <= game_over_d;
`ifdef STREAK_BONUS_EN
      streak_q       <= streak_d;
`endif
    end
  end

  assign cd_reset     = cd_reset_q;
  assign cd_stop      = cd_stop_q;
  assign cd_from      = cd_from_q;
  assign level        = level_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign round_active = round_active_q;
  assign last_win     = last_win_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_countdown_round_ctrl.sv
// Self-checking bench for countdown_round_ctrl with HOLD_CYCLES=4 and a small
// behavioural Countdown (CLOCK=4). Round results are predicted into a queue
// when a round's stimulus is chosen and compared when the round ends.
module tb_countdown_round_ctrl;

  localparam int HOLD  = 4;
  localparam int CLOCK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start_btn = 1'b0, stop_btn = 1'b0;
  logic cd_win, cd_lose, cd_reset, cd_stop, round_active, last_win, game_over;
  logic [6:0] cd_from;
  logic [2:0] level;
  logic [7:0] score;
  logic [1:0] lives;
  logic ovr_win = 1'b0, ovr_lose = 1'b0;

  // second instance: START_FROM=10, driven directly with win flags
  logic start2 = 1'b0, win2 = 1'b0, zero2 = 1'b0;
  logic cd_reset2, cd_stop2, round_active2, last_win2, game_over2;
  logic [6:0] cd_from2;
  logic [2:0] level2;
  logic [7:0] score2;
  logic [1:0] lives2;

  countdown_round_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .cd_win(cd_win), .cd_lose(cd_lose), .cd_reset(cd_reset), .cd_stop(cd_stop),
    .cd_from(cd_from), .level(level), .score(score), .lives(lives),
    .round_active(round_active), .last_win(last_win), .game_over(game_over)
  );

  countdown_round_ctrl #(.START_FROM(10), .HOLD_CYCLES(HOLD)) dut2 (
    .clk(clk), .reset(reset), .start_btn(start2), .stop_btn(zero2),
    .cd_win(win2), .cd_lose(zero2), .cd_reset(cd_reset2), .cd_stop(cd_stop2),
    .cd_from(cd_from2), .level(level2), .score(score2), .lives(lives2),
    .round_active(round_active2), .last_win(last_win2), .game_over(game_over2)
  );

  // Behavioural Countdown: loads on cd_reset, ticks every CLOCK cycles,
  // stop at 0 is a win, stop elsewhere a lose, running past 0 is a lose.
  logic [6:0] cur = '0;
  logic mwin = 1'b0, mlose = 1'b0, mrun = 1'b0;
  int tcnt = 0;
  always @(posedge clk) begin
    if (cd_reset) begin
      cur <= cd_from; mwin <= 1'b0; mlose <= 1'b0; mrun <= 1'b1; tcnt <= 0;
    end else if (cd_stop && mrun) begin
      mrun <= 1'b0;
      if (cur == 0) mwin <= 1'b1; else mlose <= 1'b1;
    end else if (mrun) begin
      if (tcnt == CLOCK - 1) begin
        tcnt <= 0;
        if (cur == 0) begin mlose <= 1'b1; mrun <= 1'b0; end
        else cur <= cur - 7'd1;
      end else begin
        tcnt <= tcnt + 1;
      end
    end
  end
  assign cd_win  = mwin | ovr_win;
  assign cd_lose = mlose | ovr_lose;

  int stop_cnt = 0;
  always @(negedge clk) if (cd_stop) stop_cnt <= stop_cnt + 1;

  int total = 0, bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // reference model of game bookkeeping
  typedef struct {
    bit win;
    int score;
    int level;
    int lives;
    int from;
  } exp_t;
  exp_t sb[$];
  int e_score = 0, e_level = 0, e_lives = 3, e_streak = 0, rnd = 0;

  function automatic int exp_from(input int lvl);
    int f;
    f = 20 - 2 * lvl;
    return (f < 5) ? 5 : f;
  endfunction

  task automatic new_game_exp();
    e_score = 0; e_level = 0; e_lives = 3; e_streak = 0;
  endtask

  task automatic push_exp(input bit w);
    exp_t t;
    if (w) begin
      e_streak = (e_streak < 15) ? e_streak + 1 : 15;
`ifdef STREAK_BONUS_EN
      e_score = e_score + e_streak;
`else
      e_score = e_score + 1;
`endif
      if (e_score > 255) e_score = 255;
      e_level = (e_level < 7) ? e_level + 1 : 7;
    end else begin
      e_lives  = e_lives - 1;
      e_streak = 0;
    end
    t.win = w; t.score = e_score; t.level = e_level; t.lives = e_lives; t.from = exp_from(e_level);
    sb.push_back(t);
  endtask

  task automatic press_start();
    start_btn = 1'b1; tick(); start_btn = 1'b0;
  endtask

  task automatic press_stop();
    stop_btn = 1'b1; tick(); stop_btn = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 100 && !round_active; i++) tick();
    check_val("run_enter", int'(round_active), 1);
  endtask

  task automatic finish_round();
    exp_t t;
    for (int i = 0; i < 300 && round_active; i++) tick();
    check_val("round_end", int'(round_active), 0);
    t = sb.pop_front();
    rnd++;
    $display("round %0d: win=%0d score=%0d level=%0d lives=%0d cd_from=%0d (want %0d/%0d/%0d/%0d/%0d)",
             rnd, last_win, score, level, lives, cd_from, t.win, t.score, t.level, t.lives, t.from);
    check_val("last_win", int'(last_win), int'(t.win));
    check_val("score", int'(score), t.score);
    check_val("level", int'(level), t.level);
    check_val("lives", int'(lives), t.lives);
    check_val("cd_from", int'(cd_from), t.from);
  endtask

  // kind: 0 stop at zero (win), 1 early stop, 2 timeout, 3 stop edge with lose same cycle
  task automatic play(input int kind);
    int s0;
    wait_run();
    s0 = stop_cnt;
    case (kind)
      0: begin
        push_exp(1'b1);
        for (int i = 0; i < 200 && cur != 0; i++) tick();
        check_val("win_wait", int'(cur), 0);
        press_stop();
      end
      1: begin
        push_exp(1'b0); tick(); press_stop();
      end
      2: push_exp(1'b0);
      default: begin
        push_exp(1'b0); tick(); tick();
        stop_btn = 1'b1; ovr_lose = 1'b1;
        tick();
        stop_btn = 1'b0; ovr_lose = 1'b0;
      end
    endcase
    finish_round();
    tick(); tick();
    check_val("stop_pulses", stop_cnt - s0, (kind < 2) ? 1 : 0);
  endtask

  initial begin
    int exp2;
    // reset state
    tick(); tick(); tick();
    check_val("rst_cd_from", int'(cd_from), 20);
    check_val("rst_score", int'(score), 0);
    check_val("rst_lives", int'(lives), 3);
    check_val("rst_level", int'(level), 0);
    check_val("rst_cd_stop", int'(cd_stop), 0);
    check_val("rst_cd_reset", int'(cd_reset), 0);
    check_val("rst_game_over", int'(game_over), 0);
    reset = 1'b0;
    tick();
    check_val("flush_stop_hi", int'(cd_stop), 1);
    tick();
    check_val("flush_stop_lo", int'(cd_stop), 0);
    check_val("idle_inactive", int'(round_active), 0);

    // first round: win, then re-arm exactly HOLD cycles after RESULT entry
    press_start();
    new_game_exp();
    check_val("arm_pulse", int'(cd_reset), 1);
    play(0);
    tick();
    check_val("rearm_early", int'(cd_reset), 0);
    tick();
    check_val("rearm_pulse", int'(cd_reset), 1);

    // lose all lives three different ways
    play(2);
    play(3);
    play(1);
    for (int i = 0; i < 20 && !game_over; i++) tick();
    check_val("game_over", int'(game_over), 1);
    tick(); tick();
    check_val("over_idle", int'(round_active), 0);

    // restart from OVER, then win enough to saturate the level
    press_start();
    new_game_exp();
    wait_run();
    check_val("ng_score", int'(score), 0);
    check_val("ng_lives", int'(lives), 3);
    check_val("ng_from", int'(cd_from), 20);
    check_val("ng_over", int'(game_over), 0);
    for (int i = 0; i < 8; i++) play(0);

    // reset in the middle of a round, then a stale win while idle
    wait_run();
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check_val("mid_rst_score", int'(score), 0);
    check_val("mid_rst_level", int'(level), 0);
    check_val("mid_rst_from", int'(cd_from), 20);
    check_val("mid_rst_active", int'(round_active), 0);
    check_val("mid_rst_last_win", int'(last_win), 0);
    reset = 1'b0;
    ovr_win = 1'b1;
    tick();
    check_val("mid_flush_stop", int'(cd_stop), 1);
    for (int i = 0; i < 8; i++) tick();
    check_val("stale_active", int'(round_active), 0);
    check_val("stale_score", int'(score), 0);
    check_val("stale_level", int'(level), 0);
    ovr_win = 1'b0;

    // START_FROM=10 instance: cd_from clamps at MIN_FROM
    check_val("d2_rst_from", int'(cd_from2), 10);
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 50 && !round_active2; i++) tick();
      check_val("d2_run", int'(round_active2), 1);
      win2 = 1'b1; tick(); win2 = 1'b0;
      for (int i = 0; i < 50 && round_active2; i++) tick();
      exp2 = (r == 0) ? 8 : ((r == 1) ? 6 : 5);
      $display("dut2 round %0d: cd_from=%0d level=%0d (want %0d/%0d)", r + 1, cd_from2, level2, exp2, r + 1);
      check_val("d2_from", int'(cd_from2), exp2);
      check_val("d2_level", int'(level2), r + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
